pc_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the program counter and the instruction-memory fetch for the image down-sampler processor. It drives the PC's load (`pc_en`/`pc_load`) and increment (`pc_incr_en`) controls, fetches instructions over a req/ack handshake into an instruction register, and hands each instruction to the datapath with a start/done handshake. It handles taken branches and a halt opcode, and counts retired instructions.

---
 rtl/pc_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Multi-cycle control FSM for the image down-sampler processor.
//                Sequences the program counter and the instruction fetch:
//                  IDLE -> LOAD -> FETCH -> DECODE -> EXEC -> FETCH ...
//                with a halt opcode that parks the FSM in HALT, and a
//                retired-instruction counter.
//
//  Ports
//    clk          : clock, all state on the rising edge
//    rst          : asynchronous, active-high reset
//    start        : begin execution (sampled in IDLE and HALT only)
//    pc_val       : current PC value (PC lives outside this block)
//    pc_en        : load PC from pc_load at the next edge
//    pc_incr_en   : increment PC at the next edge
//    pc_load      : PC load value (START_ADDR in LOAD, br_target on branch)
//    im_req       : instruction fetch request, held until im_ack
//    im_addr      : fetch address, always equal to pc_val
//    im_ack       : im_rdata valid this cycle
//    im_rdata     : fetched instruction
//    ir           : instruction register
//    exec_start   : one-cycle pulse, ir is ready for the datapath
//    exec_done    : datapath finished the current instruction
//    br_taken     : branch taken, qualified by exec_done
//    br_target    : branch target, qualified by exec_done && br_taken
//    busy         : high in every state except IDLE and HALT
//    halted       : high in HALT
//    instr_count  : number of retired instructions (wraps at 16 bits)
//
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int                ADDR_W     = 16,
    parameter int                INSTR_W    = 16,
    parameter int                OPC_W      = 4,
    parameter logic [OPC_W-1:0]  HALT_OP    = 4'hF,
    parameter logic [ADDR_W-1:0] START_ADDR = 16'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   pc_val,
    output logic                pc_en,
    output logic                pc_incr_en,
    output logic [ADDR_W-1:0]   pc_load,
    output logic                im_req,
    output logic [ADDR_W-1:0]   im_addr,
    input  logic                im_ack,
    input  logic [INSTR_W-1:0]  im_rdata,
    output logic [INSTR_W-1:0]  ir,
    output logic                exec_start,
    input  logic                exec_done,
    input  logic                br_taken,
    input  logic [ADDR_W-1:0]   br_target,
    output logic                busy,
    output logic                halted,
    output logic [15:0]         instr_count
);

    localparam int c_CNT_W = 16;

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [INSTR_W-1:0]   r_ir;
    logic [c_CNT_W-1:0]   r_instr_count;

    logic [OPC_W-1:0]     w_opcode;
    logic                 w_is_halt;
    logic                 w_ir_load;
    logic                 w_retire;
    logic                 w_branch;

    // ------------------------------------------------------------------
    // Qualified events. Every input is gated by the state in which it is
    // meaningful, so stray acks / dones in other states have no effect.
    // ------------------------------------------------------------------
    assign w_opcode  = r_ir[INSTR_W-1 -: OPC_W];
    assign w_is_halt = (w_opcode == HALT_OP);
    assign w_ir_load = (r_state == S_FETCH) && im_ack;
    assign w_retire  = (r_state == S_EXEC)  && exec_done;
    assign w_branch  = w_retire && br_taken;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Instruction register: captured only on the ack cycle of a fetch, so
    // it stays stable from DECODE through EXEC until the next fetch ack.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= '0;
        end else if (w_ir_load) begin
            r_ir <= im_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter. Not cleared by start; wraps naturally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and strobe decode. The strobes are functions of the
    // registered state (plus exec_done/br_taken for the branch load), so
    // an asynchronous reset of r_state drops them in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        pc_en       = 1'b0;
        pc_incr_en  = 1'b0;
        pc_load     = '0;
        im_req      = 1'b0;
        exec_start  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                pc_en       = 1'b1;
                pc_load     = START_ADDR;
                w_state_nxt = S_FETCH;
            end

            S_FETCH: begin
                im_req = 1'b1;
                if (im_ack) begin
                    w_state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                // A halt leaves the PC pointing at the halt instruction.
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    pc_incr_en  = 1'b1;
                    exec_start  = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                // The increment already happened in DECODE, so a taken
                // branch is a plain load here and never overlaps it.
                if (w_retire) begin
                    w_state_nxt = S_FETCH;
                    if (w_branch) begin
                        pc_en   = 1'b1;
                        pc_load = br_target;
                    end
                end
            end

            S_HALT: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered-state decodes and pass-throughs
    // ------------------------------------------------------------------
    assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted      = (r_state == S_HALT);
    assign im_addr     = pc_val;
    assign ir          = r_ir;
    assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer. A behavioural PC
//                register closes the pc_en / pc_incr_en / pc_val loop.
//                A per-cycle vector table covers start, straight-line
//                execution, branch, halt and restart; hand-written sequences
//                cover fetch wait states and asynchronous reset mid-fetch and
//                mid-exec.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [15:0] c_START = 16'h0010;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] pc_val;
    logic        pc_en;
    logic        pc_incr_en;
    logic [15:0] pc_load;
    logic        im_req;
    logic [15:0] im_addr;
    logic        im_ack;
    logic [15:0] im_rdata;
    logic [15:0] ir;
    logic        exec_start;
    logic        exec_done;
    logic        br_taken;
    logic [15:0] br_target;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    int n_cmp;
    int n_err;
    int n_overlap;

    pc_sequencer #(
        .ADDR_W     (16),
        .INSTR_W    (16),
        .OPC_W      (4),
        .HALT_OP    (4'hF),
        .START_ADDR (c_START)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc_val      (pc_val),
        .pc_en       (pc_en),
        .pc_incr_en  (pc_incr_en),
        .pc_load     (pc_load),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .ir          (ir),
        .exec_start  (exec_start),
        .exec_done   (exec_done),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural program counter driven by the sequencer's controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             pc_val <= 16'h0000;
        else if (pc_en)      pc_val <= pc_load;
        else if (pc_incr_en) pc_val <= pc_val + 16'h0001;
    end

    initial n_overlap = 0;
    always @(negedge clk) begin
        if (!rst && pc_en && pc_incr_en) n_overlap = n_overlap + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // All outputs packed in a fixed order for whole-cycle comparison.
    logic [69:0] outs;
    assign outs = {pc_en, pc_incr_en, pc_load, im_req, im_addr,
                   exec_start, busy, halted, ir, instr_count};

    typedef struct {
        logic        start;
        logic        ack;
        logic [15:0] rdata;
        logic        done;
        logic        br;
        logic [15:0] tgt;
        logic [69:0] exp;
    } vec_t;

    function automatic logic [69:0] eo(input int pe, input int inc, input int ld,
                                       input int rq, input int ad, input int es,
                                       input int bz, input int ht, input int irv,
                                       input int cn);
        logic [69:0] v;
        v = {pe[0], inc[0], 16'(ld), rq[0], 16'(ad), es[0], bz[0], ht[0],
             16'(irv), 16'(cn)};
        return v;
    endfunction

    function automatic vec_t mk(input int st, input int ak, input int rd,
                                input int dn, input int bt, input int tg,
                                input logic [69:0] e);
        vec_t r;
        r.start = st[0];
        r.ack   = ak[0];
        r.rdata = 16'(rd);
        r.done  = dn[0];
        r.br    = bt[0];
        r.tgt   = 16'(tg);
        r.exp   = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        start     = v.start;
        im_ack    = v.ack;
        im_rdata  = v.rdata;
        exec_done = v.done;
        br_taken  = v.br;
        br_target = v.tgt;
    endtask

    vec_t tbl[22];

    initial begin
        n_cmp = 0;
        n_err = 0;

        //                  start ack rdata   done br tgt      pe inc load    req addr    es bz ht ir      cnt
        tbl[0]  = mk(0,0,0,      0,0,0,      eo(0,0,0,      0,'h0000,0,0,0,'h0000,0)); // IDLE
        tbl[1]  = mk(1,0,0,      0,0,0,      eo(0,0,0,      0,'h0000,0,0,0,'h0000,0)); // IDLE, start
        tbl[2]  = mk(0,0,0,      0,0,0,      eo(1,0,'h0010, 0,'h0000,0,1,0,'h0000,0)); // LOAD
        tbl[3]  = mk(0,1,'h1234, 0,0,0,      eo(0,0,0,      1,'h0010,0,1,0,'h0000,0)); // FETCH ack
        tbl[4]  = mk(1,0,0,      0,0,0,      eo(0,1,0,      0,'h0010,1,1,0,'h1234,0)); // DECODE, start ignored
        tbl[5]  = mk(0,0,0,      1,0,0,      eo(0,0,0,      0,'h0011,0,1,0,'h1234,0)); // EXEC done
        tbl[6]  = mk(0,1,'h2345, 0,0,0,      eo(0,0,0,      1,'h0011,0,1,0,'h1234,1));
        tbl[7]  = mk(0,0,0,      0,0,0,      eo(0,1,0,      0,'h0011,1,1,0,'h2345,1));
        tbl[8]  = mk(0,0,0,      1,0,0,      eo(0,0,0,      0,'h0012,0,1,0,'h2345,1));
        tbl[9]  = mk(0,1,'h3456, 0,0,0,      eo(0,0,0,      1,'h0012,0,1,0,'h2345,2));
        tbl[10] = mk(0,0,0,      0,0,0,      eo(0,1,0,      0,'h0012,1,1,0,'h3456,2));
        tbl[11] = mk(0,0,0,      1,0,0,      eo(0,0,0,      0,'h0013,0,1,0,'h3456,2));
        tbl[12] = mk(0,1,'h4567, 0,0,0,      eo(0,0,0,      1,'h0013,0,1,0,'h3456,3)); // PC 0x13, count 3
        tbl[13] = mk(0,0,0,      0,0,0,      eo(0,1,0,      0,'h0013,1,1,0,'h4567,3));
        tbl[14] = mk(0,1,'hAAAA, 0,1,'h0999, eo(0,0,0,      0,'h0014,0,1,0,'h4567,3)); // EXEC wait, stray ack/br
        tbl[15] = mk(0,0,0,      1,1,'h0200, eo(1,0,'h0200, 0,'h0014,0,1,0,'h4567,3)); // taken branch
        tbl[16] = mk(0,1,'hF000, 0,0,0,      eo(0,0,0,      1,'h0200,0,1,0,'h4567,4)); // fetch halt
        tbl[17] = mk(0,0,0,      0,0,0,      eo(0,0,0,      0,'h0200,0,1,0,'hF000,4)); // DECODE halt
        tbl[18] = mk(0,1,'h1111, 1,1,'h0777, eo(0,0,0,      0,'h0200,0,0,1,'hF000,4)); // HALT, stray inputs
        tbl[19] = mk(1,0,0,      0,0,0,      eo(0,0,0,      0,'h0200,0,0,1,'hF000,4)); // HALT, start
        tbl[20] = mk(0,0,0,      0,0,0,      eo(1,0,'h0010, 0,'h0200,0,1,0,'hF000,4)); // reload START_ADDR
        tbl[21] = mk(0,0,0,      0,0,0,      eo(0,0,0,      1,'h0010,0,1,0,'hF000,4)); // FETCH wait 1

        rst       = 1'b1;
        start     = 1'b0;
        im_ack    = 1'b0;
        im_rdata  = 16'h0000;
        exec_done = 1'b0;
        br_taken  = 1'b0;
        br_target = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs, 70'd0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("row%0d", i), outs, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // Fetch wait states: im_req and im_addr held, ir unchanged until ack.
        drive(mk(0,0,0,0,0,0,70'd0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("fetch_wait%0d", k + 2), outs, eo(0,0,0,1,'h0010,0,1,0,'hF000,4));
            @(posedge clk);
            #1;
        end
        im_ack   = 1'b1;
        im_rdata = 16'h5678;
        @(negedge clk);
        check("fetch_ack_cycle", outs, eo(0,0,0,1,'h0010,0,1,0,'hF000,4));
        @(posedge clk);
        #1;
        im_ack = 1'b0;
        @(negedge clk);
        check("decode_after_wait", outs, eo(0,1,0,0,'h0010,1,1,0,'h5678,4));
        @(posedge clk);
        #1;

        // Reset mid-exec while a branch load is being presented.
        exec_done = 1'b1;
        br_taken  = 1'b1;
        br_target = 16'h0300;
        #1;
        check("exec_branch_before_rst", outs, eo(1,0,'h0300,0,'h0011,0,1,0,'h5678,4));
        rst = 1'b1;
        #1;
        check("rst_mid_exec", outs, 70'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        im_ack = 1'b1;

        // Stray exec_done / im_ack after reset must leave the FSM in IDLE.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("idle_spurious%0d", k), outs, 70'd0);
            @(posedge clk);
            #1;
        end
        drive(mk(1,0,0,0,0,0,70'd0));
        @(negedge clk);
        check("idle_start", outs, 70'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("restart_load", outs, eo(1,0,'h0010,0,'h0000,0,1,0,'h0000,0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("restart_fetch", outs, eo(0,0,0,1,'h0010,0,1,0,'h0000,0));

        // Reset mid-fetch: im_req drops without a clock edge.
        rst = 1'b1;
        #1;
        check("rst_mid_fetch", outs, 70'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_after_rst", outs, 70'd0);

        check("pc_en_incr_exclusive", 70'(n_overlap), 70'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
